// File: rtl/pipe_out_scheduler.sv
// Round-robin framing scheduler: shares one pipe-out endpoint among NUM_SRC FWFT source FIFOs.
// Each frame is one 0xA5 header word followed by BLOCK_WORDS payload words from the granted source.
module pipe_out_scheduler #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic                  okClk,
  input  logic                  reset,
  input  logic                  ep_read,
  output logic [31:0]           ep_datain,
  output logic                  ep_ready,
  input  logic [NUM_SRC-1:0]    src_en,
  input  logic [16*NUM_SRC-1:0] src_count,
  input  logic [32*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_read,
  output logic [31:0]           frame_count
);

  localparam int unsigned GW        = $clog2(NUM_SRC);
  localparam logic [15:0] BLOCK_CNT = 16'(BLOCK_WORDS);
  localparam logic [15:0] LAST_WORD = 16'(BLOCK_WORDS - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [31:0]   frame_count_q, frame_count_d;
  logic [31:0]   header_q, header_d;

  logic [NUM_SRC-1:0] qual;
  logic               found;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      rr_idx;
  logic [31:0]        grant_data;

  // A source qualifies only when it can supply a whole frame.
  always_comb begin
    qual = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      qual[i] = src_en[i] && (src_count[16*i +: 16] >= BLOCK_CNT);
    end
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = '0;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      rr_idx = GW'((int'(rr_ptr_q) + k) % int'(NUM_SRC));
      if (!found && qual[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // Endpoint-facing outputs: data mux and zero-latency pop strobe.
  always_comb begin
    grant_data = '0;
    src_read   = '0;
    ep_datain  = 32'h0000_0000;
    ep_ready   = (state_q != IDLE);
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (grant_q == GW'(i)) begin
        grant_data = src_data[32*i +: 32];
        src_read[i] = (state_q == DATA) && ep_read;
      end
    end
    case (state_q)
      HEADER:  ep_datain = header_q;
      DATA:    ep_datain = grant_data;
      default: ep_datain = 32'h0000_0000;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    seq_d         = seq_q;
    word_cnt_d    = word_cnt_q;
    frame_count_d = frame_count_q;
    header_d      = header_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          header_d = {SYNC_BYTE, seq_q, 8'(pick), 8'h00};
          state_d  = HEADER;
        end
      end
      HEADER: begin
        if (ep_read) begin
          word_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (ep_read) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == LAST_WORD) begin
            state_d       = IDLE;
            rr_ptr_d      = grant_q;
            seq_d         = seq_q + 8'd1;
            frame_count_d = frame_count_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= GW'(NUM_SRC - 1);
      seq_q         <= '0;
      word_cnt_q    <= '0;
      frame_count_q <= '0;
      header_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      seq_q         <= seq_d;
      word_cnt_q    <= word_cnt_d;
      frame_count_q <= frame_count_d;
      header_q      <= header_d;
    end
  end

  assign frame_count = frame_count_q;

endmodule
